// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared 16-bit SRAM.
// One access at a time: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD with Ack.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        A_Req,
  input  logic        A_WE,
  input  logic [15:0] A_Addr,
  input  logic [15:0] A_WData,
  input  logic [1:0]  A_BE,
  output logic        A_Ack,
  output logic [15:0] A_RData,
  input  logic        B_Req,
  input  logic        B_WE,
  input  logic [15:0] B_Addr,
  input  logic [15:0] B_WData,
  input  logic [1:0]  B_BE,
  output logic        B_Ack,
  output logic [15:0] B_RData,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Mem_LB,
  output logic        Mem_UB,
  output logic [15:0] Address,
  output logic [15:0] Data_ToSRAM,
  input  logic [15:0] Data_FromSRAM
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] CntInit = 4'(ACCESS_CYCLES);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdataA_q, rdataA_d;
  logic [15:0] rdataB_q, rdataB_d;
  logic        grantB;
  logic [15:0] readMasked;

  // last_q = 1 means port B was granted most recently, so A wins a tie.
  assign grantB = B_Req & (~A_Req | ~last_q);
  assign readMasked = {be_q[1] ? Data_FromSRAM[15:8] : 8'h00,
                       be_q[0] ? Data_FromSRAM[7:0]  : 8'h00};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      rdataA_q <= '0;
      rdataB_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      rdataA_q <= rdataA_d;
      rdataB_q <= rdataB_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    rdataA_d = rdataA_q;
    rdataB_d = rdataB_q;
    case (state_q)
      IDLE: begin
        if (A_Req | B_Req) begin
          sel_d   = grantB;
          last_d  = grantB;
          we_d    = grantB ? B_WE    : A_WE;
          addr_d  = grantB ? B_Addr  : A_Addr;
          wdata_d = grantB ? B_WData : A_WData;
          be_d    = grantB ? B_BE    : A_BE;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CntInit;
        state_d = ACCESS;
      end
      ACCESS: begin
        // Read data is sampled on the final strobe edge, just before HOLD.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = HOLD;
          if (!we_q) begin
            if (sel_q) rdataB_d = readMasked;
            else       rdataA_d = readMasked;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Mem_CE      = (state_q != IDLE);
  assign Mem_OE      = (state_q == ACCESS) & ~we_q;
  assign Mem_WE      = (state_q == ACCESS) & we_q;
  assign Mem_LB      = Mem_CE & be_q[0];
  assign Mem_UB      = Mem_CE & be_q[1];
  assign Address     = addr_q;
  assign Data_ToSRAM = wdata_q;
  assign A_Ack       = (state_q == HOLD) & ~sel_q;
  assign B_Ack       = (state_q == HOLD) & sel_q;
  assign A_RData     = rdataA_q;
  assign B_RData     = rdataB_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table plus scoreboard queue,
// with hand-written reset, contention and ACCESS_CYCLES sweep sequences.
module tb_sram_arbiter;

  localparam int N = 2;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
  } txn_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        A_Req, A_WE, B_Req, B_WE;
  logic [15:0] A_Addr, A_WData, B_Addr, B_WData;
  logic [1:0]  A_BE, B_BE;
  logic        A_Ack, B_Ack;
  logic [15:0] A_RData, B_RData;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB;
  logic [15:0] Address, Data_ToSRAM, Data_FromSRAM;

  logic        s1Req, s15Req;
  logic        tie0 = 1'b0;
  logic [15:0] tie16 = 16'h0000;
  logic [1:0]  tie2 = 2'b00;
  logic [1:0]  sBE = 2'b11;
  logic [15:0] sAddr = 16'h0042;
  logic [15:0] sData = 16'hA55A;
  logic        s1Ack, s1BAck, s1CE, s1OE, s1WE, s1LB, s1UB;
  logic        s15Ack, s15BAck, s15CE, s15OE, s15WE, s15LB, s15UB;
  logic [15:0] s1RData, s1BRData, s1Addr, s1Dout;
  logic [15:0] s15RData, s15BRData, s15Addr, s15Dout;

  logic [15:0] mem [0:65535];
  txn_t        sbq[$];
  int          ackCyc[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] expRdA = 16'h0000;
  logic [15:0] expRdB = 16'h0000;
  txn_t        vecs [11];

  sram_arbiter #(.ACCESS_CYCLES(N)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Req(A_Req), .A_WE(A_WE), .A_Addr(A_Addr), .A_WData(A_WData), .A_BE(A_BE),
    .A_Ack(A_Ack), .A_RData(A_RData),
    .B_Req(B_Req), .B_WE(B_WE), .B_Addr(B_Addr), .B_WData(B_WData), .B_BE(B_BE),
    .B_Ack(B_Ack), .B_RData(B_RData),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_LB(Mem_LB), .Mem_UB(Mem_UB),
    .Address(Address), .Data_ToSRAM(Data_ToSRAM), .Data_FromSRAM(Data_FromSRAM)
  );

  sram_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .A_Req(s1Req), .A_WE(tie0), .A_Addr(sAddr), .A_WData(tie16), .A_BE(sBE),
    .A_Ack(s1Ack), .A_RData(s1RData),
    .B_Req(tie0), .B_WE(tie0), .B_Addr(tie16), .B_WData(tie16), .B_BE(tie2),
    .B_Ack(s1BAck), .B_RData(s1BRData),
    .Mem_CE(s1CE), .Mem_OE(s1OE), .Mem_WE(s1WE), .Mem_LB(s1LB), .Mem_UB(s1UB),
    .Address(s1Addr), .Data_ToSRAM(s1Dout), .Data_FromSRAM(sData)
  );

  sram_arbiter #(.ACCESS_CYCLES(15)) dut15 (
    .Clk(Clk), .Reset(Reset),
    .A_Req(s15Req), .A_WE(tie0), .A_Addr(sAddr), .A_WData(tie16), .A_BE(sBE),
    .A_Ack(s15Ack), .A_RData(s15RData),
    .B_Req(tie0), .B_WE(tie0), .B_Addr(tie16), .B_WData(tie16), .B_BE(tie2),
    .B_Ack(s15BAck), .B_RData(s15BRData),
    .Mem_CE(s15CE), .Mem_OE(s15OE), .Mem_WE(s15WE), .Mem_LB(s15LB), .Mem_UB(s15UB),
    .Address(s15Addr), .Data_ToSRAM(s15Dout), .Data_FromSRAM(sData)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  assign Data_FromSRAM = mem[Address];

  // SRAM model: asynchronous read, byte-masked write on each clock edge with WE high
  initial begin
    for (int i = 0; i < 6; i++) mem[16'h0100 + 16'(i)] = 16'hA000 | 16'(i);
    mem[16'h3000] = 16'hBEEF;
    mem[16'h0010] = 16'h5566;
    mem[16'h0020] = 16'h0000;
    mem[16'h0030] = 16'hFFFF;
    forever begin
      @(posedge Clk);
      if (Mem_WE) begin
        if (Mem_LB) mem[Address][7:0]  = Data_ToSRAM[7:0];
        if (Mem_UB) mem[Address][15:8] = Data_ToSRAM[15:8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drivePort(input logic port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be, input logic req);
    if (port) begin
      B_WE = we; B_Addr = addr; B_WData = wdata; B_BE = be; B_Req = req;
    end else begin
      A_WE = we; A_Addr = addr; A_WData = wdata; A_BE = be; A_Req = req;
    end
  endtask

  // One isolated transaction from IDLE: scoreboard entry, bounded wait for Ack, latency check
  task automatic applyStimulus(input txn_t v);
    int  start;
    bit  got;
    @(negedge Clk);
    drivePort(v.port, v.we, v.addr, v.wdata, v.be, 1'b1);
    sbq.push_back(v);
    start = cyc;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge Clk);
      if (v.port ? B_Ack : A_Ack) got = 1;
    end
    checkOutput("ack_latency", got ? 32'(cyc - start) : 32'hFFFF_FFFF, 32'(N + 2));
    drivePort(v.port, v.we, v.addr, v.wdata, v.be, 1'b0);
  endtask

  // Scoreboard monitor: bus contents, strobe widths, Ack order and held read data
  initial begin
    int   oeCnt;
    int   weCnt;
    txn_t t;
    oeCnt = 0;
    weCnt = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        oeCnt = 0; weCnt = 0; expRdA = 16'h0000; expRdB = 16'h0000;
      end else begin
        if (Mem_OE) oeCnt++;
        if (Mem_WE) weCnt++;
        if (Mem_CE && sbq.size() > 0) begin
          checkOutput("address", 32'(Address), 32'(sbq[0].addr));
          checkOutput("byte_en", 32'({Mem_UB, Mem_LB}), 32'(sbq[0].be));
          if (sbq[0].we) checkOutput("wdata", 32'(Data_ToSRAM), 32'(sbq[0].wdata));
        end
        if (A_Ack || B_Ack) begin
          checkOutput("dual_ack", 32'(A_Ack & B_Ack), 0);
          if (sbq.size() == 0) begin
            checkOutput("unexpected_ack", 32'({A_Ack, B_Ack}), 0);
          end else begin
            t = sbq.pop_front();
            checkOutput("ack_port", 32'(B_Ack), 32'(t.port));
            checkOutput("oe_width", 32'(oeCnt), t.we ? 0 : N);
            checkOutput("we_width", 32'(weCnt), t.we ? N : 0);
            if (!t.we) begin
              if (t.port) expRdB = t.rdata;
              else        expRdA = t.rdata;
            end
            ackCyc.push_back(cyc);
          end
          oeCnt = 0;
          weCnt = 0;
        end
        checkOutput("a_rdata", 32'(A_RData), 32'(expRdA));
        checkOutput("b_rdata", 32'(B_RData), 32'(expRdB));
      end
    end
  end

  initial begin
    int base;
    int start;
    bit got;
    vecs[0]  = '{1'b0, 1'b0, 16'h3000, 16'h0000, 2'b11, 16'hBEEF};
    vecs[1]  = '{1'b1, 1'b1, 16'h0010, 16'h12AB, 2'b01, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'h55AB};
    vecs[3]  = '{1'b0, 1'b0, 16'h3000, 16'h0000, 2'b10, 16'hBE00};
    vecs[4]  = '{1'b0, 1'b0, 16'h3000, 16'h0000, 2'b00, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0020, 16'hC0DE, 2'b11, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 2'b01, 16'h00DE};
    vecs[7]  = '{1'b1, 1'b1, 16'h0020, 16'h7700, 2'b10, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h77DE};
    vecs[9]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 2'b10, 16'h7700};
    vecs[10] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 2'b01, 16'h00EF};

    drivePort(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0);
    drivePort(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0);
    s1Req = 1'b0;
    s15Req = 1'b0;

    #1;
    checkOutput("reset_acks", 32'({A_Ack, B_Ack}), 0);
    checkOutput("reset_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB}), 0);
    checkOutput("reset_address", 32'(Address), 0);
    checkOutput("reset_wdata", 32'(Data_ToSRAM), 0);
    checkOutput("reset_rdata", {A_RData, B_RData}, 0);
    checkOutput("reset_sweep_ctl", 32'({s1Ack, s1BAck, s1CE, s1OE, s1WE, s1LB, s1UB,
                 s15Ack, s15BAck, s15CE, s15OE, s15WE, s15LB, s15UB}), 0);
    checkOutput("reset_sweep_bus1", {s1Addr, s1Dout}, 0);
    checkOutput("reset_sweep_bus15", {s15Addr, s15Dout}, 0);
    checkOutput("reset_sweep_rd", {s1RData ^ s15RData, s1BRData ^ s15BRData}, 0);

    @(negedge Clk);
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
    checkOutput("byte_write_mem", 32'(mem[16'h0010]), 32'h55AB);
    checkOutput("upper_write_mem", 32'(mem[16'h0020]), 32'h77DE);

    // Contention: A wins first because B was granted last
    base = ackCyc.size();
    for (int i = 0; i < 6; i++)
      sbq.push_back('{1'(i % 2), 1'b0, 16'h0100 + 16'(i), 16'h0000, 2'b11, 16'hA000 | 16'(i)});
    @(negedge Clk);
    drivePort(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, 1'b1);
    drivePort(1'b1, 1'b0, 16'h0101, 16'h0000, 2'b11, 1'b1);
    fork
      begin
        bit gotA;
        for (int j = 0; j < 3; j++) begin
          gotA = 0;
          for (int k = 0; k < 60 && !gotA; k++) begin
            @(negedge Clk);
            if (A_Ack) gotA = 1;
          end
          checkOutput("contention_a_ack", 32'(gotA), 1);
          if (j < 2) A_Addr = 16'h0100 + 16'(2 * (j + 1));
          else       A_Req = 1'b0;
        end
      end
      begin
        bit gotB;
        for (int j = 0; j < 3; j++) begin
          gotB = 0;
          for (int k = 0; k < 60 && !gotB; k++) begin
            @(negedge Clk);
            if (B_Ack) gotB = 1;
          end
          checkOutput("contention_b_ack", 32'(gotB), 1);
          if (j < 2) B_Addr = 16'h0101 + 16'(2 * (j + 1));
          else       B_Req = 1'b0;
        end
      end
    join
    checkOutput("contention_ack_count", 32'(ackCyc.size() - base), 6);
    for (int j = 1; j < 6; j++)
      if (base + j < ackCyc.size())
        checkOutput("ack_interval", 32'(ackCyc[base + j] - ackCyc[base + j - 1]), N + 3);

    // Reset in the middle of a B write: strobes drop at once, nothing completes
    @(negedge Clk);
    drivePort(1'b1, 1'b1, 16'h0030, 16'h1234, 2'b11, 1'b1);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge Clk);
      if (Mem_WE) got = 1;
    end
    checkOutput("reset_reached_access", 32'(got), 1);
    #2 Reset = 1'b1;
    B_Req = 1'b0;
    #1;
    checkOutput("midreset_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB}), 0);
    checkOutput("midreset_ack", 32'({A_Ack, B_Ack}), 0);
    checkOutput("midreset_bus", {Address, Data_ToSRAM}, 0);
    checkOutput("midreset_rdata", {A_RData, B_RData}, 0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      checkOutput("idle_after_reset", 32'({Mem_CE, A_Ack, B_Ack}), 0);
    end
    checkOutput("lost_write_mem", 32'(mem[16'h0030]), 32'hFFFF);
    applyStimulus('{1'b0, 1'b0, 16'h3000, 16'h0000, 2'b11, 16'hBEEF});

    // Strobe width and Ack latency sweep for ACCESS_CYCLES = 1 and 15
    begin
      int  lat1, lat15, oe1, oe15;
      bit  done1, done15;
      lat1 = -1; lat15 = -1; oe1 = 0; oe15 = 0; done1 = 0; done15 = 0;
      @(negedge Clk);
      s1Req = 1'b1;
      s15Req = 1'b1;
      start = cyc;
      for (int k = 0; k < 40 && !(done1 && done15); k++) begin
        @(negedge Clk);
        if (s1OE && !done1) oe1++;
        if (s15OE && !done15) oe15++;
        if (s1Ack && !done1) begin done1 = 1; lat1 = cyc - start; s1Req = 1'b0; end
        if (s15Ack && !done15) begin done15 = 1; lat15 = cyc - start; s15Req = 1'b0; end
      end
      checkOutput("sweep1_latency", 32'(lat1), 3);
      checkOutput("sweep15_latency", 32'(lat15), 17);
      checkOutput("sweep1_oe_width", 32'(oe1), 1);
      checkOutput("sweep15_oe_width", 32'(oe15), 15);
      checkOutput("sweep1_rdata", 32'(s1RData), 32'hA55A);
      checkOutput("sweep15_rdata", 32'(s15RData), 32'hA55A);
    end

    repeat (3) @(negedge Clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
